updown_sweep_ctrl: RTL
======================

# updown_sweep_ctrl

Sequencing controller for the 4-bit up/down counter datapath. It owns the count register and drives it through programmed triangular sweeps between a low and a high bound, holding at each bound for a fixed dwell. Sweeps run either a set number of times or continuously until aborted. Downstream logic sees the count plus DIRECTION/STEP qualifiers, so the controller replaces free-running counters wherever bounded, repeatable ramps are needed.

## Interface
- WIDTH, 4: count width in bits (unsigned).
- DWELL, 2: extra hold cycles at each bound; each bound is held for DWELL+1 cycles.
- SWEEP_W, 8: width of the sweep-count input.

- CLOCK  in  1  rising-edge clock; the only clock.
- RESET  in  1  synchronous, active-high reset.
- START  in  1  level sampled each edge; launches a run when in IDLE.
- ABORT  in  1  stops a run; highest priority after RESET.
- LO  in  WIDTH  lower bound, latched at START.
- HI  in  WIDTH  upper bound, latched at START.
- SWEEPS  in  SWEEP_W  number of full sweeps, latched at START; 0 = run forever.
- COUNT_OUT  out  WIDTH  current count.
- DIRECTION  out  1  1 = ramping or about to ramp up, 0 = down.
- STEP  out  1  high in each cycle where COUNT_OUT was just ramped by ±1.
- BUSY  out  1  run in progress.
- DONE  out  1  one-cycle pulse on normal completion.
- CFG_ERR  out  1  one-cycle pulse when START is rejected.

## Operation
- Reset values: state IDLE, COUNT_OUT=0, DIRECTION=1, STEP=0, BUSY=0, DONE=0, CFG_ERR=0, sweep counter=0.
- Priority at each edge: RESET > ABORT > state logic.
- States are IDLE, UP, DWELL_HI, DOWN, DWELL_LO.
- IDLE with START=1 and LO>HI (unsigned):
  - CFG_ERR=1 for one cycle.
  - Remain in IDLE; COUNT_OUT is unchanged.
- IDLE with START=1 and LO≤HI:
  - Latch LO, HI, SWEEPS; set COUNT_OUT←LO, BUSY←1, DIRECTION←1; go to UP.
  - STEP stays 0 for this load.
- UP:
  - If COUNT_OUT<HI: COUNT_OUT←COUNT_OUT+1 and STEP←1.
  - Else: go to DWELL_HI with STEP←0.
- DWELL_HI: hold for DWELL+1 cycles, then go to DOWN with DIRECTION←0.
- DOWN: mirror of UP toward LO (decrement, STEP←1); at LO go to DWELL_LO.
- DWELL_LO: hold for DWELL+1 cycles, then increment the sweep counter.
  - If SWEEPS≠0 and the new count equals SWEEPS: go to IDLE with BUSY←0, DONE←1, DIRECTION←1.
  - Otherwise: go to UP with DIRECTION←1.
- When SWEEPS=0, the sweep counter wraps modulo 2^SWEEP_W and never terminates the run.
- LO==HI is legal: the ramps take zero steps and the sweep is dwells only.
- Count arithmetic never wraps, because ramps stop at the latched bounds. HI=2^WIDTH−1 and LO=0 are both legal.
- ABORT in any non-IDLE state:
  - Next edge: go to IDLE with BUSY←0, STEP←0, DIRECTION←1.
  - COUNT_OUT holds its current value; DONE is not asserted.
- ABORT while in IDLE has no effect, and overrides a simultaneous START (no launch, no CFG_ERR).
- START while BUSY is ignored. LO/HI/SWEEPS changes during a run are ignored.
- On the completion edge itself (DWELL_LO exit), ABORT wins and DONE is suppressed.

## Timing
- All outputs are registered. S denotes the edge that samples a valid START.
- COUNT_OUT=LO and BUSY=1 are visible after edge S.
- UP occupies HI−LO+1 cycles: HI−LO stepping cycles plus one cycle detecting the bound. DOWN is the same.
- Each dwell occupies DWELL+1 cycles.
- Sweep period: P = 2·(HI−LO+DWELL+2) cycles.
- Completion with SWEEPS=N: DONE=1 and BUSY=0 in the cycle following edge S+N·P; DONE returns to 0 one edge later.
- DIRECTION toggles on the edges leaving DWELL_HI and DWELL_LO, one cycle before the first STEP of the new ramp.
- A new START is accepted at the edge where DONE is high, i.e. back-to-back runs are allowed.
- RESET mid-run: all outputs take their reset values at the next edge.

## Test plan
- Reset, then LO=2, HI=5, SWEEPS=1, DWELL=2, START pulse at S:
  - COUNT_OUT is 2 at S, then 3,4,5 with STEP=1.
  - Hold at 5 with DIRECTION→0 after 4 more cycles, then 4,3,2.
  - DONE pulses after S+14, and BUSY is low from then on.
- LO=6, HI=3, START → CFG_ERR for one cycle; BUSY stays 0 and COUNT_OUT is unchanged.
- LO=0, HI=15, SWEEPS=0:
  - Runs multiple periods (P=38) with COUNT_OUT never exceeding 15 or wrapping.
  - ABORT while COUNT_OUT=9 in DOWN → IDLE with COUNT_OUT=9, BUSY=0, no DONE.
- LO=HI=7, SWEEPS=3 → COUNT_OUT stays 7 and STEP is never 1; DONE after S+3·(2·(0+2+2))=S+24.
- Simultaneous events:
  - START+ABORT in IDLE → no launch.
  - START while BUSY → ignored.
  - Changing LO/HI mid-run has no effect on the ramp.
  - New START on the DONE cycle launches immediately.
- RESET asserted mid-ramp (COUNT_OUT=4, UP) → next cycle COUNT_OUT=0, DIRECTION=1, BUSY=0, state IDLE.

Source files
------------

// File: rtl/updown_sweep_ctrl.sv
// Sweep controller for the up/down count register: triangular ramps between
// latched bounds, with a dwell at each bound, repeated N times or until aborted.
module updown_sweep_ctrl #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned DWELL   = 2,
  parameter int unsigned SWEEP_W = 8
) (
  input  logic               CLOCK,
  input  logic               RESET,
  input  logic               START,
  input  logic               ABORT,
  input  logic [WIDTH-1:0]   LO,
  input  logic [WIDTH-1:0]   HI,
  input  logic [SWEEP_W-1:0] SWEEPS,
  output logic [WIDTH-1:0]   COUNT_OUT,
  output logic               DIRECTION,
  output logic               STEP,
  output logic               BUSY,
  output logic               DONE,
  output logic               CFG_ERR
);

  localparam int unsigned DW_W = (DWELL > 0) ? $clog2(DWELL + 1) : 1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    UP       = 3'd1,
    DWELL_HI = 3'd2,
    DOWN     = 3'd3,
    DWELL_LO = 3'd4
  } state_t;

  state_t             state, state_d;
  logic [WIDTH-1:0]   count, count_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [SWEEP_W-1:0] sweeps_q, sweeps_d;
  logic [SWEEP_W-1:0] sweep_cnt, sweep_cnt_d;
  logic [SWEEP_W-1:0] sweep_inc;
  logic [DW_W-1:0]    dwell_cnt, dwell_d;
  logic               dir, dir_d;
  logic               step, step_d;
  logic               busy, busy_d;
  logic               done, done_d;
  logic               cfg_err, cfg_err_d;
  logic               dwell_last;

  assign sweep_inc  = sweep_cnt + SWEEP_W'(1);
  assign dwell_last = (dwell_cnt == DW_W'(DWELL));

  // State and datapath registers
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state     <= IDLE;
      count     <= '0;
      lo_q      <= '0;
      hi_q      <= '0;
      sweeps_q  <= '0;
      sweep_cnt <= '0;
      dwell_cnt <= '0;
      dir       <= 1'b1;
      step      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      state     <= state_d;
      count     <= count_d;
      lo_q      <= lo_d;
      hi_q      <= hi_d;
      sweeps_q  <= sweeps_d;
      sweep_cnt <= sweep_cnt_d;
      dwell_cnt <= dwell_d;
      dir       <= dir_d;
      step      <= step_d;
      busy      <= busy_d;
      done      <= done_d;
      cfg_err   <= cfg_err_d;
    end
  end

  // Next-state and next-output logic; STEP/DONE/CFG_ERR are single-cycle pulses
  always_comb begin
    state_d     = state;
    count_d     = count;
    lo_d        = lo_q;
    hi_d        = hi_q;
    sweeps_d    = sweeps_q;
    sweep_cnt_d = sweep_cnt;
    dwell_d     = dwell_cnt;
    dir_d       = dir;
    step_d      = 1'b0;
    busy_d      = busy;
    done_d      = 1'b0;
    cfg_err_d   = 1'b0;

    if (ABORT && (state != IDLE)) begin
      state_d = IDLE;
      busy_d  = 1'b0;
      dir_d   = 1'b1;
      dwell_d = '0;
    end else begin
      case (state)
        IDLE: begin
          if (START && !ABORT) begin
            if (LO > HI) begin
              cfg_err_d = 1'b1;
            end else begin
              lo_d        = LO;
              hi_d        = HI;
              sweeps_d    = SWEEPS;
              sweep_cnt_d = '0;
              dwell_d     = '0;
              count_d     = LO;
              busy_d      = 1'b1;
              dir_d       = 1'b1;
              state_d     = UP;
            end
          end
        end
        UP: begin
          if (count < hi_q) begin
            count_d = count + WIDTH'(1);
            step_d  = 1'b1;
          end else begin
            dwell_d = '0;
            state_d = DWELL_HI;
          end
        end
        DWELL_HI: begin
          if (dwell_last) begin
            dwell_d = '0;
            dir_d   = 1'b0;
            state_d = DOWN;
          end else begin
            dwell_d = dwell_cnt + DW_W'(1);
          end
        end
        DOWN: begin
          if (count > lo_q) begin
            count_d = count - WIDTH'(1);
            step_d  = 1'b1;
          end else begin
            dwell_d = '0;
            state_d = DWELL_LO;
          end
        end
        DWELL_LO: begin
          if (dwell_last) begin
            dwell_d     = '0;
            dir_d       = 1'b1;
            sweep_cnt_d = sweep_inc;
            // SWEEPS==0 runs forever; the counter just wraps
            if ((sweeps_q != '0) && (sweep_inc == sweeps_q)) begin
              busy_d  = 1'b0;
              done_d  = 1'b1;
              state_d = IDLE;
            end else begin
              state_d = UP;
            end
          end else begin
            dwell_d = dwell_cnt + DW_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign COUNT_OUT = count;
  assign DIRECTION = dir;
  assign STEP      = step;
  assign BUSY      = busy;
  assign DONE      = done;
  assign CFG_ERR   = cfg_err;

endmodule
